// File: rtl/mul_pkg.sv
// mul_pkg: shared types and constants for the nibble-sequenced 8x8 multiplier
package mul_pkg;
    localparam int NW = 4;
    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
    localparam logic [3:0] SHIFT [0:3] = '{4'd0, 4'd4, 4'd4, 4'd8};
endpackage

// File: rtl/mul8_nibble_sequencer.sv
// mul8_nibble_sequencer: 8x8->16 unsigned multiply over four cycles on an external 4x4 core
//   in_valid/in_ready/in_a/in_b     operand handshake
//   mul_m/mul_q -> core, mul_p <-   combinational 4x4 core product, same cycle
//   out_valid/out_ready/out_prod    result handshake, held until accepted
//   busy                            high while multiplying or holding a result
module mul8_nibble_sequencer
    import mul_pkg::*;
#(
    parameter int NW        = 4,
    parameter bit ZERO_SKIP = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2*NW-1:0] in_a,
    input  logic [2*NW-1:0] in_b,
    output logic [NW-1:0]   mul_m,
    output logic [NW-1:0]   mul_q,
    input  logic [2*NW-1:0] mul_p,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [4*NW-1:0] out_prod,
    output logic            busy
);
    state_t          state, state_n;
    logic [1:0]      step;
    logic [2*NW-1:0] a_r, b_r;
    logic [4*NW-1:0] acc;
    logic            zero_hit;

    assign zero_hit = ZERO_SKIP && (in_a == '0 || in_b == '0);

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = in_valid ? (zero_hit ? DONE : MUL) : IDLE;
            MUL:     state_n = (step == 2'd3) ? DONE : MUL;
            DONE:    state_n = out_ready ? IDLE : DONE;
            default: state_n = IDLE;
        endcase
    end

    // step[0] picks the a nibble, step[1] the b nibble
    always_comb begin
        in_ready  = state == IDLE;
        busy      = state != IDLE;
        out_valid = state == DONE;
        out_prod  = acc;
        mul_m     = state == MUL ? (step[0] ? a_r[2*NW-1:NW] : a_r[NW-1:0]) : '0;
        mul_q     = state == MUL ? (step[1] ? b_r[2*NW-1:NW] : b_r[NW-1:0]) : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_r  <= '0;
            b_r  <= '0;
            acc  <= '0;
            step <= '0;
        end else if (state == IDLE && in_valid) begin
            a_r  <= in_a;
            b_r  <= in_b;
            acc  <= '0;
            step <= '0;
        end else if (state == MUL) begin
            acc  <= acc + ({{(2*NW){1'b0}}, mul_p} << SHIFT[step]);
            step <= step + 2'd1;
        end
    end
endmodule

// File: tb/tb_mul8_nibble_sequencer.sv
// tb_mul8_nibble_sequencer: directed and swept checks against a cycle-level product model
module tb_mul8_nibble_sequencer;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready, busy;
    logic [7:0]  in_a, in_b, mul_p;
    logic [3:0]  mul_m, mul_q;
    logic [15:0] out_prod;

    logic        zs_valid, zs_in_ready, zs_out_valid, zs_busy;
    logic [7:0]  zs_a, zs_b, zs_p;
    logic [3:0]  zs_m, zs_q;
    logic [15:0] zs_prod;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mul8_nibble_sequencer #(.NW(4), .ZERO_SKIP(1'b0)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .mul_m(mul_m), .mul_q(mul_q), .mul_p(mul_p),
        .out_valid(out_valid), .out_ready(out_ready), .out_prod(out_prod), .busy(busy)
    );

    mul8_nibble_sequencer #(.NW(4), .ZERO_SKIP(1'b1)) dut_zs (
        .clk(clk), .rst(rst), .in_valid(zs_valid), .in_ready(zs_in_ready),
        .in_a(zs_a), .in_b(zs_b), .mul_m(zs_m), .mul_q(zs_q), .mul_p(zs_p),
        .out_valid(zs_out_valid), .out_ready(1'b1), .out_prod(zs_prod), .busy(zs_busy)
    );

    assign mul_p = mul_m * mul_q;
    assign zs_p  = zs_m * zs_q;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: phase 0 idle, 1..4 working on partial product phase-1, 5 result pending
    int         m_phase = 0;
    logic [7:0] m_a = 0, m_b = 0;

    always @(posedge clk) begin
        if (rst)
            m_phase <= 0;
        else if (m_phase == 0) begin
            if (in_valid) begin
                m_a <= in_a;
                m_b <= in_b;
                m_phase <= 1;
            end
        end else if (m_phase < 5)
            m_phase <= m_phase + 1;
        else if (out_ready)
            m_phase <= 0;
    end

    // Partial-product order: a.lo*b.lo, a.hi*b.lo, a.lo*b.hi, a.hi*b.hi
    always @(negedge clk) begin
        if (!rst) begin
            int exp_m, exp_q;
            exp_m = 0;
            exp_q = 0;
            case (m_phase)
                1: begin exp_m = m_a % 16; exp_q = m_b % 16; end
                2: begin exp_m = m_a / 16; exp_q = m_b % 16; end
                3: begin exp_m = m_a % 16; exp_q = m_b / 16; end
                4: begin exp_m = m_a / 16; exp_q = m_b / 16; end
                default: ;
            endcase
            chk("cyc_in_ready", in_ready, m_phase == 0);
            chk("cyc_busy", busy, m_phase != 0);
            chk("cyc_out_valid", out_valid, m_phase == 5);
            chk("cyc_mul_m", mul_m, exp_m);
            chk("cyc_mul_q", mul_q, exp_q);
            if (m_phase == 5)
                chk("cyc_out_prod", out_prod, m_a * m_b);
        end
    end

    // Issue one operand pair on the main DUT and measure edges from acceptance to out_valid
    task automatic op(input logic [7:0] a, input logic [7:0] b, output int edges, output int prod);
        int w = 0;
        while (!in_ready && w < 20) begin @(posedge clk); #1; w++; end
        chk("op_ready_wait", in_ready, 1);
        in_valid = 1; in_a = a; in_b = b;
        @(posedge clk); #1;
        in_valid = 0; in_a = ~a; in_b = ~b;
        edges = 1;
        while (!out_valid && edges < 20) begin @(posedge clk); #1; edges++; end
        prod = out_prod;
        if (out_ready) begin @(posedge clk); #1; end
    endtask

    initial begin
        int e, p;
        rst = 1; in_valid = 0; in_a = 0; in_b = 0; out_ready = 1;
        zs_valid = 0; zs_a = 0; zs_b = 0;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_mul_m", mul_m, 0);
        chk("rst_mul_q", mul_q, 0);
        chk("rst_out_prod", out_prod, 0);
        @(posedge clk); #1;

        // 0x12*0x34: nibble order and latency pinned literally
        in_valid = 1; in_a = 8'h12; in_b = 8'h34;
        @(posedge clk); #1;
        in_valid = 0; in_a = 8'hEE; in_b = 8'hEE;
        chk("s0_m", mul_m, 2); chk("s0_q", mul_q, 4);
        @(posedge clk); #1;
        chk("s1_m", mul_m, 1); chk("s1_q", mul_q, 4);
        @(posedge clk); #1;
        chk("s2_m", mul_m, 2); chk("s2_q", mul_q, 3);
        @(posedge clk); #1;
        chk("s3_m", mul_m, 1); chk("s3_q", mul_q, 3);
        chk("s3_not_valid", out_valid, 0);
        @(posedge clk); #1;
        chk("x12_valid", out_valid, 1);
        chk("x12_prod", out_prod, 16'h03A8);
        @(posedge clk); #1;
        chk("x12_handoff", out_valid, 0);

        op(8'hFF, 8'hFF, e, p);
        chk("ff_edges", e, 5);
        chk("ff_prod", p, 16'hFE01);
        op(8'h00, 8'h77, e, p);
        chk("zero_noskip_edges", e, 5);
        chk("zero_noskip_prod", p, 0);

        for (int a = 0; a < 256; a += 5)
            for (int b = 0; b < 256; b += 7) begin
                op(a[7:0], b[7:0], e, p);
                chk("sweep_prod", p, a * b);
            end

        // Stalled result: held stable, new operands refused
        out_ready = 0;
        op(8'h0F, 8'h10, e, p);
        chk("stall_edges", e, 5);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1; in_a = 8'h55; in_b = 8'h66;
            chk("stall_valid", out_valid, 1);
            chk("stall_prod", out_prod, 16'h00F0);
            chk("stall_in_ready", in_ready, 0);
            @(posedge clk); #1;
        end
        in_valid = 0; out_ready = 1;
        @(posedge clk); #1;
        chk("stall_release", out_valid, 0);
        chk("stall_idle", in_ready, 1);

        // Reset during step2 abandons the operation
        in_valid = 1; in_a = 8'hAB; in_b = 8'hCD;
        @(posedge clk); #1;
        in_valid = 0;
        repeat (2) begin @(posedge clk); #1; end
        chk("abort_at_s2_m", mul_m, 4'hB);
        chk("abort_at_s2_q", mul_q, 4'hC);
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        chk("abort_out_valid", out_valid, 0);
        chk("abort_in_ready", in_ready, 1);
        chk("abort_busy", busy, 0);
        chk("abort_acc", out_prod, 0);
        op(8'd3, 8'd5, e, p);
        chk("after_abort_prod", p, 16'h000F);

        // Zero-skip instance
        zs_valid = 1; zs_a = 8'h00; zs_b = 8'h77;
        @(posedge clk); #1;
        zs_valid = 0; zs_a = 8'h12; zs_b = 8'h34;
        chk("zs_hit_valid", zs_out_valid, 1);
        chk("zs_hit_prod", zs_prod, 0);
        chk("zs_hit_mul_m", zs_m, 0);
        @(posedge clk); #1;
        chk("zs_hit_handoff", zs_out_valid, 0);
        zs_valid = 1;
        @(posedge clk); #1;
        zs_valid = 0;
        e = 1;
        while (!zs_out_valid && e < 20) begin @(posedge clk); #1; e++; end
        chk("zs_nonzero_edges", e, 5);
        chk("zs_nonzero_prod", zs_prod, 16'h03A8);
        @(posedge clk); #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
